// File: rtl/fir_out_decim_if.sv
// Stream bundle for fir_out_decim: filter samples in, rescaled samples out.
// The master side drives samples and consumer ready; the slave side is the output stage.
interface fir_out_decim_if #(
  parameter int unsigned DW_IN  = 16,
  parameter int unsigned DW_OUT = 8
);
  logic                     in_valid;
  logic signed [DW_IN-1:0]  Yn;
  logic signed [DW_OUT-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in_valid,
    output Yn,
    output out_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  Yn,
    input  out_ready,
    output out_data,
    output out_valid
  );
endinterface

// File: rtl/fir_out_decim.sv
// FIR output stage: decimate, rescale to DW_OUT bits with round-half-up and
// saturation, buffer in a FWFT FIFO and present over valid/ready.
// Sticky sat/ovf flags report clipping and dropped samples.
module fir_out_decim #(
  parameter int unsigned DW_IN  = 16,
  parameter int unsigned DW_OUT = 8,
  parameter int unsigned SHIFT  = 8,
  parameter int unsigned DECIM  = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       Rst,
  fir_out_decim_if.slave             bus,
  input  logic                       clr_flags,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       sat,
  output logic                       ovf
);

  localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  // One guard bit so the rounding add cannot overflow.
  localparam int unsigned EW = DW_IN + 1;

  localparam logic signed [EW-1:0] RND_HALF = EW'(1 << (SHIFT - 1));
  localparam logic signed [EW-1:0] SAT_HI   = EW'((1 << (DW_OUT - 1)) - 1);
  // Bitwise inverse of 2^k-1 is -2^k in two's complement.
  localparam logic signed [EW-1:0] SAT_LO   = ~SAT_HI;

  // Decimation
  logic [PW-1:0] phase_q, phase_d;
  logic          keep;

  // Rescale
  logic signed [EW-1:0]     yn_ext;
  logic signed [EW-1:0]     rnd_sum;
  logic signed [EW-1:0]     t_val;
  logic signed [DW_OUT-1:0] scaled;
  logic                     clip;

  // Stage 1
  logic                     s1_valid_q;
  logic signed [DW_OUT-1:0] s1_data_q, s1_data_d;

  // FIFO
  logic signed [DW_OUT-1:0] mem [DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]            rd_ptr_nxt;
  logic [LW-1:0]            level_q, level_d;
  logic signed [DW_OUT-1:0] out_data_q, out_data_d;
  logic                     push, pop, full, wr_en, drop;

  // Flags
  logic sat_q, sat_d;
  logic ovf_q, ovf_d;

  // Phase counter advances only on valid filter samples; keep on phase 0.
  always_comb begin
    phase_d = phase_q;
    if (bus.in_valid) begin
      if (phase_q == PW'(DECIM - 1)) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + PW'(1);
      end
    end
    keep = bus.in_valid && (phase_q == '0);
  end

  // Round-half-up via bias then arithmetic shift, then clip to DW_OUT range.
  always_comb begin
    yn_ext  = {bus.Yn[DW_IN-1], bus.Yn};
    rnd_sum = yn_ext + RND_HALF;
    t_val   = rnd_sum >>> SHIFT;
    clip    = 1'b0;
    scaled  = t_val[DW_OUT-1:0];
    if (t_val > SAT_HI) begin
      scaled = SAT_HI[DW_OUT-1:0];
      clip   = 1'b1;
    end else if (t_val < SAT_LO) begin
      scaled = SAT_LO[DW_OUT-1:0];
      clip   = 1'b1;
    end
  end

  // Stage-1 data only loads on kept samples; sat set event beats clear.
  always_comb begin
    s1_data_d = keep ? scaled : s1_data_q;
    sat_d     = sat_q;
    if (keep && clip) begin
      sat_d = 1'b1;
    end else if (clr_flags) begin
      sat_d = 1'b0;
    end
  end

  // FIFO control: a push into a full FIFO only lands if a pop frees a slot.
  always_comb begin
    push       = s1_valid_q;
    full       = (level_q == LW'(DEPTH));
    pop        = (level_q != '0) && bus.out_ready;
    wr_en      = push && (!full || pop);
    drop       = push && full && !pop;
    rd_ptr_nxt = rd_ptr_q + AW'(1);

    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_nxt : rd_ptr_q;

    level_d = level_q;
    if (wr_en && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!wr_en && pop) begin
      level_d = level_q - LW'(1);
    end

    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_flags) begin
      ovf_d = 1'b0;
    end
  end

  // Registered head: track what the head will be after this edge, hold when empty.
  always_comb begin
    out_data_d = out_data_q;
    if (level_d != '0) begin
      if ((level_q == '0) || ((level_q == LW'(1)) && pop)) begin
        // Head slot is (or becomes) the entry being written this edge.
        out_data_d = s1_data_q;
      end else if (pop) begin
        out_data_d = mem[rd_ptr_nxt];
      end
    end
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (Rst) begin
      phase_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      out_data_q <= '0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      s1_valid_q <= keep;
      s1_data_q  <= s1_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      out_data_q <= out_data_d;
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage array; contents are invalidated by pointer reset, not cleared.
  always_ff @(posedge clk) begin
    if (!Rst && wr_en) begin
      mem[wr_ptr_q] <= s1_data_q;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = (level_q != '0);
  assign level         = level_q;
  assign sat           = sat_q;
  assign ovf           = ovf_q;

endmodule
